// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter sharing one (19,8) single-error-correcting decoder between two requesters.
// Define DECODER_ARB_STATS_EN to build the saturating corrected/uncorrectable counters; otherwise they read 0.
module decoder_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [18:0]      req0_cx,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [18:0]      req1_cx,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_d,
    output logic             resp_id,
    output logic             resp_corr,
    output logic             resp_uncorr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    // Row k: which data bits (bit j <-> cx[11+j]) feed syndrome bit k.
    // Rows 1 and 6 are intentionally identical.
    localparam logic [7:0] EQ [11] = '{
        8'b1111_1010,
        8'b0010_1100,
        8'b0000_1011,
        8'b1000_1000,
        8'b0101_0011,
        8'b1001_0111,
        8'b0010_1100,
        8'b0000_1101,
        8'b1000_1011,
        8'b1101_0010,
        8'b0011_1101
    };

    typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic [18:0] cx_q;
    logic        id_q;
    logic [7:0]  resp_data_q;
    logic        resp_id_q;
    logic        resp_corr_q;
    logic        resp_uncorr_q;

    logic        idle;
    logic        gnt;
    logic        accept;
    logic [10:0] syn;
    logic [7:0]  flip;
    logic        col_hit;
    logic        syn_parity;
    logic [7:0]  dec_data_d;
    logic        dec_corr_d;
    logic        dec_uncorr_d;

    // Syndrome signature produced by a single flip of data bit j.
    function automatic logic [10:0] column(input int j);
        logic [10:0] c;
        for (int k = 0; k < 11; k++) c[k] = EQ[k][j];
        return c;
    endfunction

    // Ready is masked by rst_n so nothing appears accepted while reset is held.
    assign idle       = (state_q == IDLE) && rst_n;
    assign gnt        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = idle && req0_valid && !gnt;
    assign req1_ready = idle && req1_valid && gnt;
    assign accept     = req0_ready || req1_ready;

    // Syndrome of the held codeword: own parity bit XOR the selected data bits.
    always_comb begin
        syn = '0;
        for (int k = 0; k < 11; k++) syn[k] = cx_q[k] ^ (^(cx_q[18:11] & EQ[k]));
    end

    // Column match; scanning downward lets the lowest matching data bit win.
    always_comb begin
        flip    = '0;
        col_hit = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            if (syn == column(j)) begin
                flip    = 8'b1 << j;
                col_hit = 1'b1;
            end
        end
    end

    // Classification: one-hot syndrome is a parity-bit error, data untouched.
    always_comb begin
        syn_parity   = $onehot(syn);
        dec_corr_d   = syn_parity || col_hit;
        dec_uncorr_d = (syn != '0) && !dec_corr_d;
        dec_data_d   = syn_parity ? cx_q[18:11] : cx_q[18:11] ^ flip;
    end

    // Control FSM with registered response fields held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cx_q          <= '0;
            id_q          <= 1'b0;
            resp_data_q   <= '0;
            resp_id_q     <= 1'b0;
            resp_corr_q   <= 1'b0;
            resp_uncorr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q      <= DECODE;
                    cx_q         <= gnt ? req1_cx : req0_cx;
                    id_q         <= gnt;
                    last_grant_q <= gnt;
                end
                DECODE: begin
                    state_q       <= RESP;
                    resp_data_q   <= dec_data_d;
                    resp_id_q     <= id_q;
                    resp_corr_q   <= dec_corr_d;
                    resp_uncorr_q <= dec_uncorr_d;
                end
                RESP: if (resp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid  = state_q == RESP;
    assign resp_d      = resp_data_q;
    assign resp_id     = resp_id_q;
    assign resp_corr   = resp_corr_q;
    assign resp_uncorr = resp_uncorr_q;

`ifdef DECODER_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_corr_q;
    logic [CNT_W-1:0] cnt_uncorr_q;

    // Saturating statistics, bumped as each result leaves DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else if (state_q == DECODE) begin
            if (dec_corr_d && cnt_corr_q != '1) cnt_corr_q <= cnt_corr_q + 1'b1;
            if (dec_uncorr_d && cnt_uncorr_q != '1) cnt_uncorr_q <= cnt_uncorr_q + 1'b1;
        end
    end

    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;
`else
    assign cnt_corr   = '0;
    assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter: vector table, hand sequences and randomized traffic against a codeword-search reference.
module tb_decoder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
    logic [18:0] req0_cx = '0, req1_cx = '0;
    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_corr, resp_uncorr;
    logic [7:0]  resp_d;
    logic [15:0] cnt_corr, cnt_uncorr;

    int n_chk = 0;
    int n_fail = 0;
    int ecc = 0;
    int ecu = 0;

    always #5 clk = ~clk;

    decoder_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_cx(req0_cx), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cx(req1_cx), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_d(resp_d),
        .resp_id(resp_id), .resp_corr(resp_corr), .resp_uncorr(resp_uncorr),
        .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    int eql [11][6] = '{
        '{12, 14, 15, 16, 17, 18}, '{13, 14, 16, -1, -1, -1}, '{11, 12, 14, -1, -1, -1},
        '{14, 18, -1, -1, -1, -1}, '{11, 12, 15, 17, -1, -1}, '{11, 12, 13, 15, 18, -1},
        '{13, 14, 16, -1, -1, -1}, '{11, 13, 14, -1, -1, -1}, '{11, 12, 14, 18, -1, -1},
        '{12, 15, 17, 18, -1, -1}, '{11, 13, 14, 15, 16, -1}
    };

    function automatic logic [10:0] syn_of(input logic [18:0] c);
        logic [10:0] s;
        for (int k = 0; k < 11; k++) begin
            s[k] = c[k];
            for (int m = 0; m < 6; m++) if (eql[k][m] >= 0) s[k] = s[k] ^ c[eql[k][m]];
        end
        return s;
    endfunction

    function automatic logic [18:0] encode(input logic [7:0] d);
        return {d, syn_of({d, 11'b0})};
    endfunction

    // Reference: a codeword is correctable iff some single-bit flip yields a zero syndrome.
    function automatic void ref_decode(input logic [18:0] c, output logic [7:0] d, output bit corr, output bit uncorr);
        logic [18:0] t;
        d = c[18:11];
        corr = 1'b0;
        uncorr = 1'b0;
        if (syn_of(c) == 11'd0) return;
        for (int i = 0; i < 19; i++) begin
            t = c ^ (19'd1 << i);
            if (syn_of(t) == 11'd0) begin
                d = t[18:11];
                corr = 1'b1;
                return;
            end
        end
        uncorr = 1'b1;
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef DECODER_ARB_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [18:0] rnd_cx();
        logic [18:0] c;
        int ne;
        c = encode(8'($urandom));
        ne = $urandom_range(0, 2);
        for (int i = 0; i < ne; i++) c[$urandom_range(0, 18)] ^= 1'b1;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts();
        chk("cnt_corr", cnt_corr, cnt_exp(ecc));
        chk("cnt_uncorr", cnt_uncorr, cnt_exp(ecu));
    endtask

    task automatic run_txn(input bit r, input logic [18:0] cx, input int hold,
                           input logic [7:0] ed, input bit ec, input bit eu);
        if (r) begin req1_valid = 1'b1; req1_cx = cx; end
        else   begin req0_valid = 1'b1; req0_cx = cx; end
        #1;
        chk("accept_ready", r ? req1_ready : req0_ready, 1);
        chk("other_ready", r ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_cx = 19'($urandom);
        req1_cx = 19'($urandom);
        #1;
        chk("decode_no_valid", resp_valid, 0);
        tick();
        #1;
        ecc += int'(ec);
        ecu += int'(eu);
        chk("resp_valid", resp_valid, 1);
        chk("resp_d", resp_d, ed);
        chk("resp_id", resp_id, r);
        chk("resp_corr", resp_corr, ec);
        chk("resp_uncorr", resp_uncorr, eu);
        chk_counts();
        repeat (hold) begin
            tick();
            #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_d", resp_d, ed);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("resp_done", resp_valid, 0);
    endtask

    typedef struct {
        bit          r;
        logic [7:0]  data;
        logic [18:0] err;
        int          hold;
        logic [7:0]  ed;
        bit          ec;
        bit          eu;
    } vec_t;

    vec_t tbl [8];

    bit          job, last, g, vis, mid, mc, mu;
    int          age;
    logic [7:0]  md;

    initial begin
        tbl[0] = '{1'b0, 8'hA5, 19'h00000, 0, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'hA5, 19'h04000, 0, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'hA5, 19'h00008, 2, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'hA5, 19'h40800, 1, 8'h24, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 19'h00000, 0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'hFF, 19'h40000, 3, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h5A, 19'h00003, 0, 8'h5A, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 8'h81, 19'h00800, 0, 8'h81, 1'b1, 1'b0};

        // Reset with both requesters valid.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_cx = encode(8'h11);
        req1_cx = encode(8'h22);
        repeat (3) tick();
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_d", resp_d, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_corr", resp_corr, 0);
        chk("rst_uncorr", resp_uncorr, 0);
        chk_counts();
        tick();
        rst_n = 1'b1;
        #1;
        chk("first_ready0", req0_ready, 1);
        chk("first_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("dec_ready1", req1_ready, 0);
        tick();
        #1;
        chk("first_resp_valid", resp_valid, 1);
        chk("first_resp_id", resp_id, 0);
        chk("first_resp_d", resp_d, 8'h11);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        chk("second_ready1", req1_ready, 1);
        chk("second_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        chk("second_resp_id", resp_id, 1);
        chk("second_resp_d", resp_d, 8'h22);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Vector table, alternating requesters.
        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].r, encode(tbl[i].data) ^ tbl[i].err, tbl[i].hold, tbl[i].ed, tbl[i].ec, tbl[i].eu);

        // Backpressure with both requesters waiting; req0 wins (req1 granted last).
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_cx = encode(8'h3C) ^ 19'h10000;
        req1_cx = encode(8'hC3);
        #1;
        chk("bp_ready0", req0_ready, 1);
        chk("bp_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        ecc++;
        chk("bp_valid", resp_valid, 1);
        req0_valid = 1'b1;
        repeat (5) begin
            tick();
            #1;
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_d", resp_d, 8'h3C);
            chk("bp_hold_id", resp_id, 0);
            chk("bp_hold_corr", resp_corr, 1);
            chk("bp_hold_ready0", req0_ready, 0);
            chk("bp_hold_ready1", req1_ready, 0);
        end
        chk_counts();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req0_valid = 1'b0;
        #1;
        chk("bp_next_ready1", req1_ready, 1);
        chk("bp_next_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        chk("bp_next_id", resp_id, 1);
        chk("bp_next_d", resp_d, 8'hC3);
        chk("bp_next_corr", resp_corr, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset while in DECODE drops the in-flight corrected result.
        req0_valid = 1'b1;
        req0_cx = encode(8'h77) ^ 19'h02000;
        #1;
        chk("mr_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        ecc = 0;
        ecu = 0;
        chk("mr_valid", resp_valid, 0);
        chk("mr_d", resp_d, 0);
        chk("mr_id", resp_id, 0);
        chk("mr_corr", resp_corr, 0);
        chk_counts();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        #1;
        chk("mr_after_valid", resp_valid, 0);
        chk_counts();

        // Randomized traffic against the reference.
        job = 1'b0;
        last = 1'b1;
        age = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_cx = rnd_cx();
            req1_cx = rnd_cx();
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            vis = job && age >= 1;
            g = (req0_valid && req1_valid) ? !last : req1_valid;
            chk("rnd_ready0", req0_ready, !job && req0_valid && !g);
            chk("rnd_ready1", req1_ready, !job && req1_valid && g);
            chk("rnd_valid", resp_valid, vis);
            if (vis) begin
                chk("rnd_d", resp_d, md);
                chk("rnd_id", resp_id, mid);
                chk("rnd_corr", resp_corr, mc);
                chk("rnd_uncorr", resp_uncorr, mu);
            end
            chk_counts();
            if (vis && resp_ready) job = 1'b0;
            else if (job && age == 0) begin
                age = 1;
                ecc += int'(mc);
                ecu += int'(mu);
            end else if (!job && (req0_valid || req1_valid)) begin
                job = 1'b1;
                age = 0;
                last = g;
                mid = g;
                ref_decode(g ? req1_cx : req0_cx, md, mc, mu);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_arbiter.md
# decoder_arbiter

Shares one single-error-correcting (19,8) syndrome decoder between two requesters. Each requester submits a 19-bit codeword over a valid/ready handshake. The block arbitrates round-robin, registers the codeword, computes the syndrome and corrected data, and returns an 8-bit result tagged with requester ID and error status. It sits between the channel front-ends and the downstream data consumer, and is the only sequential wrapper around the combinational decoder datapath.

## Interface
Parameters:
- CNT_W, default 16: width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a codeword.
- req0_cx  in  19  requester 0 codeword; bits [18:11] are data, bits [10:0] are parity.
- req0_ready  out  1  requester 0 codeword accepted this cycle when high together with req0_valid.
- req1_valid, req1_cx, req1_ready  in / in / out  1 / 19 / 1  same as above, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_d  out  8  corrected data bits [18:11].
- resp_id  out  1  requester index of the result.
- resp_corr  out  1  exactly one bit was corrected.
- resp_uncorr  out  1  syndrome is nonzero and does not match any column; resp_d is raw cx[18:11].
- cnt_corr  out  CNT_W  saturating count of corrected responses.
- cnt_uncorr  out  CNT_W  saturating count of uncorrectable responses.

## Operation
- FSM states and transitions:
  - IDLE: when any req*_valid is high, go to DECODE.
  - DECODE: always go to RESP.
  - RESP: when resp_ready is high, go to IDLE.
- Grant:
  - Only in IDLE: req_ready = grant & valid, combinational, for exactly one requester.
  - Both valid: grant the requester not granted last. The last_grant register resets to 1, so requester 0 wins the first contention.
  - Single valid: that requester wins. last_grant updates on every accept.
- On accept, latch cx into cx_q and the grant index into id_q.
- DECODE computes the syndrome from cx_q. Each bit s[k] is the XOR of cx_q[k] and the listed data bits:
  - s0: 12, 14, 15, 16, 17, 18
  - s1: 13, 14, 16
  - s2: 11, 12, 14
  - s3: 14, 18
  - s4: 11, 12, 15, 17
  - s5: 11, 12, 13, 15, 18
  - s6: 13, 14, 16
  - s7: 11, 13, 14
  - s8: 11, 12, 14, 18
  - s9: 12, 15, 17, 18
  - s10: 11, 13, 14, 15, 16
- Column of data bit j: the set of k whose equation lists j.
- Classification and result:
  - s == 0: clean; corr = 0, uncorr = 0.
  - s one-hot: parity-bit error; corr = 1, data unchanged.
  - s equals the column of data bit j: flip bit j; corr = 1. If two columns are equal, the lowest j wins (s1 and s6 have identical equations, by design).
  - Otherwise: uncorr = 1, data unchanged.
- At the end of DECODE, register resp_d, resp_id, resp_corr and resp_uncorr. In RESP they are held stable; resp_valid is high only in RESP.
- Counters increment when the block leaves DECODE and saturate at all-ones.

## Timing
- Reset (asynchronous): state = IDLE, all resp_* = 0, cnt_* = 0, last_grant = 1, req*_ready = 0.
- Reset is honoured in any state. An in-flight result is dropped and is not counted.
- Latency: accept on edge N, resp_valid high after edge N+2.
- Throughput: one codeword per 3 cycles with resp_ready held high.
- resp_valid stays high and resp_* stay stable until the cycle resp_ready is sampled high.
- No new accept occurs while in DECODE or RESP; req*_ready = 0 there.
- The requester's cx is sampled only in the accept cycle and may change afterwards.

## Configuration
- DECODER_ARB_STATS_EN defined: cnt_corr and cnt_uncorr are implemented as described.
- Undefined: the counter registers are absent and cnt_corr and cnt_uncorr are tied to 0. All other behaviour is identical.

## Test plan
- Reset with both valid high: ready = 0 during reset. After release, req0 is accepted first, then req1 after req0's response. resp_id sequence is 0, 1.
- Clean codeword: data 0xA5 with correct parity -> resp_d = 0xA5, corr = 0, uncorr = 0, resp_valid exactly 2 cycles after accept.
- Single data error: flip cx[14] of a clean codeword -> resp_d restored, corr = 1. Flip cx[3] -> data unchanged, corr = 1. cnt_corr = 2.
- Double error: flip cx[11] and cx[18] -> uncorr = 1, resp_d = raw cx[18:11], cnt_uncorr increments.
- Backpressure: hold resp_ready = 0 for 5 cycles -> resp_* stable and both ready = 0 throughout. Accept of the next requester occurs the cycle after resp_ready goes high.
- Mid-operation reset asserted in DECODE -> outputs 0 immediately and counters unchanged at 0. Without DECODER_ARB_STATS_EN, the counters read 0 in every scenario.
